scarv_soc_intc: RTL and testbench
=================================

Name: scarv_soc_intc

Overview:
- Memory-mapped external interrupt controller between SoC peripheral interrupt lines and the CPU `cpu_int_external` / `cpu_int_ext_cause` inputs.
- Synchronises up to 16 sources, latches them as edge- or level-triggered pending bits, masks them, and presents the lowest-numbered active source as the cause.
- Software reaches it through a CPU-style req/gnt, recv/ack register port decoded by the SoC interconnect.

Parameters:
- NIRQ, 16, number of interrupt sources (1..16; cause width fixed at 4).
- BASE_MASK, 32'h0000000F, address bits used for register decode (word offsets 0x0..0xC).

Ports:
- g_clk  in  1  system clock.
- g_resetn  in  1  reset; one clock, synchronous active-low, all state cleared when low.
- irq_src  in  NIRQ  raw peripheral interrupt lines, asynchronous to g_clk.
- mem_req  in  1  register access request.
- mem_gnt  out  1  request accepted this cycle.
- mem_wen  in  1  1 = write, 0 = read.
- mem_strb  in  4  write byte strobes.
- mem_addr  in  32  byte address; only [3:2] decoded.
- mem_wdata  in  32  write data.
- mem_recv  out  1  response valid.
- mem_ack  in  1  response accepted by requester.
- mem_error  out  1  response is an error.
- mem_rdata  out  32  read data.
- cpu_int_external  out  1  to CPU: any enabled interrupt pending.
- cpu_int_ext_cause  out  4  to CPU: index of lowest pending+enabled source.

Behaviour:
- Reset:
  - All registers, synchroniser flops and edge-history flops are 0.
  - Outputs are 0: `mem_gnt`, `mem_recv`, `mem_error`, `mem_rdata`, `cpu_int_external`, `cpu_int_ext_cause`.
- Synchroniser: two flops per source (`sync`); edge-history flop `prev`. Input-to-pending latency is 3 cycles.
- Pending update, per bit i:
  - EDGE[i]=1: set on `sync & ~prev`.
  - EDGE[i]=0: set while `sync`=1.
  - Clear by PENDING W1C or by CLAIM read of i.
  - Set wins over a same-cycle clear.
  - Level source still high after a clear re-pends next cycle.
- Register map (word offset; bits at index ≥ NIRQ read 0, writes ignored):
  - 0x0 PENDING: R; W1C respecting `mem_strb`.
  - 0x4 ENABLE: RW, byte-strobed.
  - 0x8 EDGE: RW, byte-strobed; 1 = rising-edge, 0 = level.
  - 0xC CLAIM:
    - R returns {valid[31], 27'b0, id[3:0]}, where valid = `cpu_int_external` at grant cycle and id = current cause.
    - If valid, clears PENDING[id] in the grant cycle.
    - Write to 0xC: no effect, `mem_error`=1.
- Bus FSM (states IDLE, RESP):
  - IDLE: `mem_gnt` = `mem_req` combinationally. On req, perform access, capture rdata/error, go to RESP next cycle.
  - RESP: `mem_recv`=1, `mem_gnt`=0, rdata/error held stable. When `mem_ack`, return to IDLE in the next cycle; no back-to-back grant in the ack cycle.
  - Writes respond with `mem_rdata`=0.
- Interrupt outputs:
  - Registered: `cpu_int_external` <= |(PENDING & ENABLE).
  - `cpu_int_ext_cause` <= lowest set index of (PENDING & ENABLE); otherwise held at its last value.
  - One cycle latency from a pending/enable change.
- Lowest index has highest priority; no nesting/preemption state inside this block.
- Reset asserted mid-transaction aborts the response; no `mem_recv` after reset is released.

Test Plan:
- Reset, then read all four registers → all 0, `mem_error`=0; `cpu_int_external`=0, cause=0.
- EDGE=0x0004, ENABLE=0x0004; pulse `irq_src[2]` for 1 cycle → PENDING=0x0004, `cpu_int_external`=1 and cause=2 at pulse+4 cycles; CLAIM read returns 0x80000002, next-cycle PENDING=0, external=0.
- Level mode: ENABLE=0x0001, hold `irq_src[0]`=1; W1C PENDING=0x1 → bit re-pends next cycle; drop the line, then W1C → stays 0.
- Sources 5 and 9 pending and enabled → cause=5; set ENABLE=0x0200 → cause=9 one cycle after the write.
- Edge pulse on `irq_src[3]` in the same cycle as a PENDING W1C of bit 3 → bit 3 remains 1.
- Write to 0xC → `mem_recv` with `mem_error`=1, no state change; hold `mem_ack`=0 for 3 cycles → `mem_recv` and `mem_rdata` stable, `mem_gnt`=0 throughout.

Source files
------------

// File: rtl/scarv_soc_intc.sv
// scarv_soc_intc - memory-mapped external interrupt controller.
//
// Sits between SoC peripheral interrupt lines and the CPU external interrupt
// inputs. Each source is synchronised, latched into a pending bit (edge or
// level triggered), masked by ENABLE, and the lowest-numbered active source
// is presented to the CPU as the cause.
//
// Ports:
//   g_clk, g_resetn        clock, synchronous active-low reset
//   irq_src[NIRQ-1:0]      raw (asynchronous) peripheral interrupt lines
//   mem_req/gnt/wen/strb/addr/wdata   register request channel
//   mem_recv/ack/error/rdata          register response channel
//   cpu_int_external       any enabled interrupt pending (registered)
//   cpu_int_ext_cause      index of lowest pending+enabled source (registered)
//
// Register map (word offset, bits >= NIRQ read 0 / ignore writes):
//   0x0 PENDING  R, write-1-to-clear (byte strobed)
//   0x4 ENABLE   RW (byte strobed)
//   0x8 EDGE     RW (byte strobed), 1 = rising edge, 0 = level
//   0xC CLAIM    R: {valid, 27'b0, id}, clears PENDING[id] when valid.
//                W: no effect, error response.

// Per-source front end: 2-flop synchroniser, edge history and pending bit.
module scarv_soc_intc_src (
    input  logic g_clk,
    input  logic g_resetn,
    input  logic irq,        // raw asynchronous line
    input  logic edge_mode,  // 1 = rising edge, 0 = level
    input  logic clr,        // W1C or claim clear this cycle
    output logic pend
);
    logic meta;
    logic sync;
    logic prev;
    logic set;

    assign set = edge_mode ? (sync & ~prev) : sync;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
            pend <= 1'b0;
        end else begin
            meta <= irq;
            sync <= meta;
            prev <= sync;
            // A new event arriving in the same cycle as a clear must not be lost.
            pend <= (pend & ~clr) | set;
        end
    end
endmodule

module scarv_soc_intc #(
    parameter int          NIRQ      = 16,
    parameter logic [31:0] BASE_MASK = 32'h0000000F
) (
    input  logic            g_clk,
    input  logic            g_resetn,
    input  logic [NIRQ-1:0] irq_src,
    input  logic            mem_req,
    output logic            mem_gnt,
    input  logic            mem_wen,
    input  logic [3:0]      mem_strb,
    input  logic [31:0]     mem_addr,
    input  logic [31:0]     mem_wdata,
    output logic            mem_recv,
    input  logic            mem_ack,
    output logic            mem_error,
    output logic [31:0]     mem_rdata,
    output logic            cpu_int_external,
    output logic [3:0]      cpu_int_ext_cause
);
    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_EDGE    = 2'd2;
    localparam logic [1:0] REG_CLAIM   = 2'd3;

    state_t          state;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] enable;
    logic [NIRQ-1:0] edge_mode;
    logic [NIRQ-1:0] active;
    logic [NIRQ-1:0] clr;
    logic [NIRQ-1:0] w1c_clr;
    logic [NIRQ-1:0] claim_clr;
    logic [31:0]     wmask;
    logic [31:0]     offs;
    logic [1:0]      reg_sel;
    logic [3:0]      lo_idx;
    logic            wr_acc;
    logic            rd_acc;
    logic [31:0]     acc_rdata;
    logic            acc_err;
    logic            unused_ok;

    // Fold bits that are intentionally not decoded.
    assign unused_ok = &{1'b0, mem_addr, mem_wdata};

    assign offs    = mem_addr & BASE_MASK;
    assign reg_sel = offs[3:2];
    assign wmask   = {{8{mem_strb[3]}}, {8{mem_strb[2]}}, {8{mem_strb[1]}}, {8{mem_strb[0]}}};

    // Grant only from IDLE; held low while reset is asserted.
    assign mem_gnt = g_resetn && (state == IDLE) && mem_req;
    assign wr_acc  = mem_gnt &&  mem_wen;
    assign rd_acc  = mem_gnt && !mem_wen;

    assign active = pending & enable;

    // Lowest index wins: scan downwards so the last match is the lowest.
    always_comb begin
        lo_idx = 4'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (active[i]) lo_idx = 4'(i);
        end
    end

    // Clear sources: W1C of PENDING, or a valid CLAIM read of the current cause.
    always_comb begin
        w1c_clr   = '0;
        claim_clr = '0;
        if (wr_acc && reg_sel == REG_PENDING)
            w1c_clr = mem_wdata[NIRQ-1:0] & wmask[NIRQ-1:0];
        for (int i = 0; i < NIRQ; i++) begin
            if (rd_acc && reg_sel == REG_CLAIM && cpu_int_external &&
                cpu_int_ext_cause == 4'(i))
                claim_clr[i] = 1'b1;
        end
    end

    assign clr = w1c_clr | claim_clr;

    // Read data / error for the access being granted this cycle.
    always_comb begin
        acc_rdata = 32'd0;
        acc_err   = 1'b0;
        if (mem_wen) begin
            acc_err = (reg_sel == REG_CLAIM);
        end else begin
            case (reg_sel)
                REG_PENDING: acc_rdata[NIRQ-1:0] = pending;
                REG_ENABLE:  acc_rdata[NIRQ-1:0] = enable;
                REG_EDGE:    acc_rdata[NIRQ-1:0] = edge_mode;
                default:     acc_rdata = {cpu_int_external, 27'd0, cpu_int_ext_cause};
            endcase
        end
    end

    genvar g;
    generate
        for (g = 0; g < NIRQ; g++) begin : g_src
            scarv_soc_intc_src u_src (
                .g_clk     (g_clk),
                .g_resetn  (g_resetn),
                .irq       (irq_src[g]),
                .edge_mode (edge_mode[g]),
                .clr       (clr[g]),
                .pend      (pending[g])
            );
        end
    endgenerate

    // Control registers and CPU-facing outputs.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            enable            <= '0;
            edge_mode         <= '0;
            cpu_int_external  <= 1'b0;
            cpu_int_ext_cause <= 4'd0;
        end else begin
            if (wr_acc && reg_sel == REG_ENABLE)
                enable <= (enable & ~wmask[NIRQ-1:0]) | (mem_wdata[NIRQ-1:0] & wmask[NIRQ-1:0]);
            if (wr_acc && reg_sel == REG_EDGE)
                edge_mode <= (edge_mode & ~wmask[NIRQ-1:0]) | (mem_wdata[NIRQ-1:0] & wmask[NIRQ-1:0]);
            cpu_int_external <= |active;
            // Cause keeps its last value once nothing is active.
            if (|active)
                cpu_int_ext_cause <= lo_idx;
        end
    end

    // Bus response FSM: one outstanding access, response held until acked.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state     <= IDLE;
            mem_recv  <= 1'b0;
            mem_error <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        state     <= RESP;
                        mem_recv  <= 1'b1;
                        mem_error <= acc_err;
                        mem_rdata <= acc_rdata;
                    end
                end
                default: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_recv <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_scarv_soc_intc.sv
// Self-checking bench for scarv_soc_intc. Expected responses are queued when
// a register access is issued and popped when the response comes back.
module tb_scarv_soc_intc;
    localparam int NIRQ = 16;

    logic            g_clk = 1'b0;
    logic            g_resetn = 1'b0;
    logic [NIRQ-1:0] irq_src = '0;
    logic            mem_req = 1'b0;
    logic            mem_gnt;
    logic            mem_wen = 1'b0;
    logic [3:0]      mem_strb = 4'h0;
    logic [31:0]     mem_addr = 32'd0;
    logic [31:0]     mem_wdata = 32'd0;
    logic            mem_recv;
    logic            mem_ack = 1'b0;
    logic            mem_error;
    logic [31:0]     mem_rdata;
    logic            cpu_int_external;
    logic [3:0]      cpu_int_ext_cause;

    int n_tests = 0;
    int n_fail  = 0;
    logic [32:0] sb_q[$];   // {error, rdata}

    scarv_soc_intc #(.NIRQ(NIRQ), .BASE_MASK(32'h0000000F)) dut (
        .g_clk             (g_clk),
        .g_resetn          (g_resetn),
        .irq_src           (irq_src),
        .mem_req           (mem_req),
        .mem_gnt           (mem_gnt),
        .mem_wen           (mem_wen),
        .mem_strb          (mem_strb),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_recv          (mem_recv),
        .mem_ack           (mem_ack),
        .mem_error         (mem_error),
        .mem_rdata         (mem_rdata),
        .cpu_int_external  (cpu_int_external),
        .cpu_int_ext_cause (cpu_int_ext_cause)
    );

    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One register access. hold = cycles to keep mem_ack low (with mem_req
    // still high) once the response is up, to check nothing new is granted.
    task automatic bus(input logic wen, input logic [3:0] off, input logic [31:0] wd,
                       input logic [3:0] strb, input logic [31:0] exp_rd,
                       input logic exp_err, input int hold, input string tag);
        logic [32:0] e;
        int n;
        sb_q.push_back({exp_err, exp_rd});
        @(negedge g_clk);
        mem_req   = 1'b1;
        mem_wen   = wen;
        mem_addr  = {28'd0, off};
        mem_wdata = wd;
        mem_strb  = strb;
        #1 chk({tag, ".gnt"}, {31'd0, mem_gnt}, 32'd1);
        @(posedge g_clk); #1;
        mem_req = (hold > 0);
        n = 0;
        while (!mem_recv && n < 8) begin
            @(posedge g_clk); #1;
            n++;
        end
        e = sb_q.pop_front();
        if (!mem_recv) begin
            chk({tag, ".recv_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, ".rdata"}, mem_rdata, e[31:0]);
            chk({tag, ".err"}, {31'd0, mem_error}, {31'd0, e[32]});
            for (int k = 0; k < hold; k++) begin
                @(posedge g_clk); #1;
                chk({tag, ".hold_recv"}, {31'd0, mem_recv}, 32'd1);
                chk({tag, ".hold_rdata"}, mem_rdata, e[31:0]);
                chk({tag, ".hold_gnt"}, {31'd0, mem_gnt}, 32'd0);
            end
            mem_ack = 1'b1;
            if (hold > 0) chk({tag, ".ack_gnt"}, {31'd0, mem_gnt}, 32'd0);
            @(posedge g_clk); #1;
            mem_ack = 1'b0;
            mem_req = 1'b0;
            chk({tag, ".recv_drop"}, {31'd0, mem_recv}, 32'd0);
        end
    endtask

    task automatic rd(input logic [3:0] off, input logic [31:0] exp, input string tag);
        bus(1'b0, off, 32'd0, 4'h0, exp, 1'b0, 0, tag);
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] strb,
                      input string tag);
        bus(1'b1, off, d, strb, 32'd0, 1'b0, 0, tag);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge g_clk);
        #1;
        chk("rst.gnt",   {31'd0, mem_gnt}, 32'd0);
        chk("rst.recv",  {31'd0, mem_recv}, 32'd0);
        chk("rst.err",   {31'd0, mem_error}, 32'd0);
        chk("rst.rdata", mem_rdata, 32'd0);
        chk("rst.ext",   {31'd0, cpu_int_external}, 32'd0);
        chk("rst.cause", {28'd0, cpu_int_ext_cause}, 32'd0);
        g_resetn = 1'b1;
        rd(4'h0, 32'd0, "rst.pending");
        rd(4'h4, 32'd0, "rst.enable");
        rd(4'h8, 32'd0, "rst.edge");
        rd(4'hC, 32'd0, "rst.claim");

        // Edge-triggered source 2: pending after 3 edges, output after 4
        wr(4'h8, 32'h0004, 4'hF, "e2.edge");
        wr(4'h4, 32'h0004, 4'hF, "e2.en");
        irq_src[2] = 1'b1;
        @(posedge g_clk); #1;
        irq_src[2] = 1'b0;
        repeat (2) @(posedge g_clk);
        #1 chk("e2.ext_early", {31'd0, cpu_int_external}, 32'd0);
        @(posedge g_clk); #1;
        chk("e2.ext", {31'd0, cpu_int_external}, 32'd1);
        chk("e2.cause", {28'd0, cpu_int_ext_cause}, 32'd2);
        rd(4'h0, 32'h0004, "e2.pending");
        rd(4'hC, 32'h80000002, "e2.claim");
        chk("e2.ext_after", {31'd0, cpu_int_external}, 32'd0);
        chk("e2.cause_held", {28'd0, cpu_int_ext_cause}, 32'd2);
        rd(4'h0, 32'h0, "e2.pending_after");

        // Level-triggered source 0
        wr(4'h8, 32'h0, 4'hF, "lv.edge");
        wr(4'h4, 32'h0001, 4'hF, "lv.en");
        irq_src[0] = 1'b1;
        repeat (4) @(posedge g_clk);
        #1;
        chk("lv.ext", {31'd0, cpu_int_external}, 32'd1);
        chk("lv.cause", {28'd0, cpu_int_ext_cause}, 32'd0);
        wr(4'h0, 32'h1, 4'hF, "lv.w1c_hi");
        rd(4'h0, 32'h1, "lv.repend");
        irq_src[0] = 1'b0;
        repeat (3) @(posedge g_clk);
        wr(4'h0, 32'h1, 4'hF, "lv.w1c_lo");
        rd(4'h0, 32'h0, "lv.cleared");
        chk("lv.ext_off", {31'd0, cpu_int_external}, 32'd0);

        // Priority between sources 5 and 9
        wr(4'h8, 32'h0220, 4'hF, "pr.edge");
        wr(4'h4, 32'h0220, 4'hF, "pr.en");
        #1 irq_src[5] = 1'b1; irq_src[9] = 1'b1;
        @(posedge g_clk); #1;
        irq_src[5] = 1'b0; irq_src[9] = 1'b0;
        repeat (5) @(posedge g_clk);
        #1;
        chk("pr.ext", {31'd0, cpu_int_external}, 32'd1);
        chk("pr.cause5", {28'd0, cpu_int_ext_cause}, 32'd5);
        wr(4'h4, 32'h0200, 4'hF, "pr.en9");
        chk("pr.cause9", {28'd0, cpu_int_ext_cause}, 32'd9);
        rd(4'hC, 32'h80000009, "pr.claim9");
        rd(4'h0, 32'h0020, "pr.pending5");
        wr(4'h0, 32'h0020, 4'b0010, "pr.w1c_wrong_strb");
        rd(4'h0, 32'h0020, "pr.strb_kept");
        wr(4'h0, 32'h0020, 4'b0001, "pr.w1c");
        rd(4'h0, 32'h0, "pr.cleared");

        // Edge event coinciding with W1C of the same bit: set wins
        wr(4'h8, 32'h0008, 4'hF, "sw.edge");
        irq_src[3] = 1'b1;
        @(posedge g_clk); #1;
        irq_src[3] = 1'b0;
        @(posedge g_clk); #1;
        wr(4'h0, 32'h0008, 4'hF, "sw.w1c");
        rd(4'h0, 32'h0008, "sw.pending");
        wr(4'h0, 32'h0008, 4'hF, "sw.cleanup");

        // CLAIM write: error response held while ack is withheld
        bus(1'b1, 4'hC, 32'hFFFFFFFF, 4'hF, 32'd0, 1'b1, 3, "cw");
        rd(4'h8, 32'h0008, "cw.edge_kept");
        rd(4'h4, 32'h0200, "cw.en_kept");
        rd(4'h0, 32'h0, "cw.pending_kept");

        // Byte strobes and bits above NIRQ
        wr(4'h4, 32'hFFFFFFFF, 4'b0010, "st.en");
        rd(4'h4, 32'h0000FF00, "st.en_rd");
        wr(4'h8, 32'hFFFFFFFF, 4'hF, "st.edge");
        rd(4'h8, 32'h0000FFFF, "st.edge_rd");

        // Reset in the middle of a transaction
        @(negedge g_clk);
        mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h4;
        @(posedge g_clk); #1;
        mem_req = 1'b0;
        chk("mr.recv", {31'd0, mem_recv}, 32'd1);
        g_resetn = 1'b0;
        @(posedge g_clk); #1;
        chk("mr.recv_rst", {31'd0, mem_recv}, 32'd0);
        g_resetn = 1'b1;
        repeat (2) @(posedge g_clk);
        #1 chk("mr.recv_after", {31'd0, mem_recv}, 32'd0);
        rd(4'h4, 32'h0, "mr.en_cleared");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
